// File: rtl/gui_pkg.sv
// Shared constants for the GUI pixel path: colours, framebuffer geometry and 640x480@60 VGA timing.
// Also holds the shift-and-add pixel address helper used by both framebuffer ports.
package gui_pkg;

    localparam logic [2:0] WHITE = 3'b111;
    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] RED   = 3'b100;
    localparam logic [2:0] BACKGROUND = WHITE;

    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int ADDR_W   = 15;

    localparam logic [7:0]        FB_W_L  = 8'(FB_W);
    localparam logic [6:0]        FB_H_L  = 7'(FB_H);
    localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);

    localparam logic [9:0] H_VIS  = 10'd640;
    localparam logic [9:0] H_FP   = 10'd16;
    localparam logic [9:0] H_SYNC = 10'd96;
    localparam logic [9:0] H_BP   = 10'd48;
    localparam logic [9:0] V_VIS  = 10'd480;
    localparam logic [9:0] V_FP   = 10'd10;
    localparam logic [9:0] V_SYNC = 10'd2;
    localparam logic [9:0] V_BP   = 10'd33;

    localparam logic [9:0] H_TOTAL      = H_VIS + H_FP + H_SYNC + H_BP;
    localparam logic [9:0] V_TOTAL      = V_VIS + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST       = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST       = V_TOTAL - 10'd1;
    localparam logic [9:0] H_SYNC_START = H_VIS + H_FP;
    localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam logic [9:0] V_SYNC_START = V_VIS + V_FP;
    localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

    typedef enum logic {
        CLR_IDLE,
        CLR_ACTIVE
    } clr_state_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

    // y*160 + x as (y<<7) + (y<<5) + x, so no multiplier is inferred.
    function automatic logic [ADDR_W-1:0] fb_addr(input logic [7:0] px, input logic [6:0] py);
        return {1'b0, py, 7'b0} + {3'b0, py, 5'b0} + {7'b0, px};
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// 800x525 scan counters with hs/vs/blank decode, delayed two stages to line up with
// the registered framebuffer read and the colour output register.
module vga_timing_gen
    import gui_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] px_o,
    output logic [6:0] py_o,
    output logic       visible_o,
    output logic       blank_n_s1_o,
    output logic       hs_o,
    output logic       vs_o,
    output logic       blank_n_o
);

    logic [9:0] h_q, h_d;
    logic [9:0] v_q, v_d;
    sync_t      sync_now;
    sync_t      s1_q, s2_q;

    always_comb begin
        h_d = h_q + 10'd1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end
    end

    always_comb begin
        sync_now.hs      = !((h_q >= H_SYNC_START) && (h_q < H_SYNC_END));
        sync_now.vs      = !((v_q >= V_SYNC_START) && (v_q < V_SYNC_END));
        sync_now.blank_n = (h_q < H_VIS) && (v_q < V_VIS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q  <= '0;
            v_q  <= '0;
            s1_q <= SYNC_IDLE;
            s2_q <= SYNC_IDLE;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            s1_q <= sync_now;
            s2_q <= s1_q;
        end
    end

    // Each stored pixel covers a 4x4 block of screen pixels.
    assign px_o         = h_q[9:2];
    assign py_o         = v_q[8:2];
    assign visible_o    = sync_now.blank_n;
    assign blank_n_s1_o = s1_q.blank_n;
    assign hs_o         = s2_q.hs;
    assign vs_o         = s2_q.vs;
    assign blank_n_o    = s2_q.blank_n;

endmodule

// File: rtl/vga_pixel_sink.sv
// Pixel-plot receiver: 160x120x3 dual-port framebuffer scanned out as 640x480@60 VGA.
// Define CLEAR_ON_RESET_EN to sweep the framebuffer to BACKGROUND after every reset.
module vga_pixel_sink
    import gui_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       plot,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    output logic       busy,
    output logic       drop,
    output logic [2:0] vga_colour,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank_n
);

    logic [2:0] fb_mem [FB_DEPTH];

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_col_q, wr_col_d;
    logic              drop_q, drop_d;
    logic [2:0]        col_q, col_d;
    logic [2:0]        rd_data_q;
    logic              accept;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [2:0]        ram_wdata;
    logic [ADDR_W-1:0] rd_addr;

    logic [7:0] scan_px;
    logic [6:0] scan_py;
    logic       scan_visible;
    logic       blank_n_s1;

    vga_timing_gen u_timing (
        .clock        (clock),
        .reset        (reset),
        .px_o         (scan_px),
        .py_o         (scan_py),
        .visible_o    (scan_visible),
        .blank_n_s1_o (blank_n_s1),
        .hs_o         (vga_hs),
        .vs_o         (vga_vs),
        .blank_n_o    (vga_blank_n)
    );

`ifdef CLEAR_ON_RESET_EN
    clr_state_t        clr_state_q, clr_state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    always_comb begin
        clr_state_d = clr_state_q;
        clr_addr_d  = clr_addr_q;
        case (clr_state_q)
            CLR_ACTIVE: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == FB_LAST) begin
                    clr_state_d = CLR_IDLE;
                    clr_addr_d  = '0;
                end
            end
            default: ;
        endcase
    end

    // Reset lands directly in the sweep so busy is already high while reset is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clr_state_q <= CLR_ACTIVE;
            clr_addr_q  <= '0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_addr_q  <= clr_addr_d;
        end
    end

    assign busy = (clr_state_q == CLR_ACTIVE);
`else
    assign busy = 1'b0;
`endif

    always_comb begin
        accept    = plot && (x < FB_W_L) && (y < FB_H_L) && !busy;
        wr_en_d   = accept;
        wr_addr_d = fb_addr(x, y);
        wr_col_d  = colour;
        drop_d    = plot && !accept;
        col_d     = blank_n_s1 ? rd_data_q : BLACK;
    end

    always_comb begin
        ram_we    = wr_en_q;
        ram_waddr = wr_addr_q;
        ram_wdata = wr_col_q;
`ifdef CLEAR_ON_RESET_EN
        if (clr_state_q == CLR_ACTIVE) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = BACKGROUND;
        end
`endif
    end

    assign rd_addr = scan_visible ? fb_addr(scan_px, scan_py) : '0;

    // Read and write share one block so a same-address collision returns the old word.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            fb_mem[ram_waddr] <= ram_wdata;
        end
        rd_data_q <= fb_mem[rd_addr];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_col_q  <= '0;
            drop_q    <= 1'b0;
            col_q     <= BLACK;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_col_q  <= wr_col_d;
            drop_q    <= drop_d;
            col_q     <= col_d;
        end
    end

    assign drop       = drop_q;
    assign vga_colour = col_q;

endmodule

// File: tb/tb_vga_pixel_sink.sv
// Self-checking bench: random plots against a frame-level model of the framebuffer and scan timing.
module tb_vga_pixel_sink;
    import gui_pkg::*;

    localparam int H_TOT = 800;
    localparam int V_TOT = 525;
    localparam int DEPTH = 19200;
`ifdef CLEAR_ON_RESET_EN
    localparam bit CLR = 1'b1;
    localparam int R0  = 10;
`else
    localparam bit CLR = 1'b0;
    localparam int R0  = 0;
`endif
    localparam int RF = 4 * (R0 + 7) * H_TOT + 80;
    localparam int SCAN_END = 4 * (R0 + 8) * H_TOT;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       plot = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       busy, drop, vga_hs, vga_vs, vga_blank_n;
    logic [2:0] vga_colour;

    vga_pixel_sink dut (
        .clock(clock), .reset(reset), .plot(plot), .x(x), .y(y), .colour(colour),
        .busy(busy), .drop(drop), .vga_colour(vga_colour),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_blank_n(vga_blank_n)
    );

    always #20 clock = ~clock;

    logic [2:0] m_fb [DEPTH];
    bit         m_known [DEPTH];
    int         cyc, out_c;
    bit         pend_we;
    int         pend_addr;
    logic [2:0] pend_col;
    logic [2:0] m_rd;
    bit         m_rd_known;
    logic [2:0] exp_col;
    bit         exp_col_known, exp_hs, exp_vs, exp_blank, exp_drop, exp_busy;
    logic [2:0] rf_old, rf_new;
    int         n_checks = 0;
    int         n_pass = 0;

    function automatic int m_h(int c); return c % H_TOT; endfunction
    function automatic int m_v(int c); return (c / H_TOT) % V_TOT; endfunction
    function automatic bit m_vis(int c); return (m_h(c) < 640) && (m_v(c) < 480); endfunction
    function automatic bit m_hs(int c); return !((m_h(c) >= 656) && (m_h(c) <= 751)); endfunction
    function automatic bit m_vs(int c); return !((m_v(c) >= 490) && (m_v(c) <= 491)); endfunction
    function automatic int m_addr(int c); return (m_v(c) / 4) * 160 + m_h(c) / 4; endfunction

    // Drives one cycle of inputs and advances the reference model across the clock edge.
    task automatic tick(input bit p, input int px, input int py, input logic [2:0] pc);
        logic [2:0] prev_rd;
        bit prev_known, busy_before, acc;
        plot = p; x = px[7:0]; y = py[6:0]; colour = pc;
        @(posedge clock);
        prev_rd = m_rd; prev_known = m_rd_known;
        if (m_vis(cyc)) begin
            m_rd = m_fb[m_addr(cyc)]; m_rd_known = m_known[m_addr(cyc)];
        end else begin
            m_rd_known = 1'b0;
        end
        out_c = cyc - 1;
        if (out_c < 0) begin
            exp_hs = 1'b1; exp_vs = 1'b1; exp_blank = 1'b0; exp_col = 3'b000; exp_col_known = 1'b1;
        end else begin
            exp_hs = m_hs(out_c); exp_vs = m_vs(out_c); exp_blank = m_vis(out_c);
            exp_col = exp_blank ? prev_rd : 3'b000;
            exp_col_known = !exp_blank || prev_known;
        end
        busy_before = CLR && (cyc < DEPTH);
        if (busy_before) begin
            m_fb[cyc] = BACKGROUND; m_known[cyc] = 1'b1;
        end else if (pend_we) begin
            m_fb[pend_addr] = pend_col; m_known[pend_addr] = 1'b1;
        end
        acc = p && (px < 160) && (py < 120) && !busy_before;
        pend_we = acc; pend_addr = py * 160 + px; pend_col = pc;
        exp_drop = p && !acc;
        cyc++;
        exp_busy = CLR && (cyc < DEPTH);
        #1;
    endtask

    task automatic release_reset();
        reset = 1'b0; cyc = 0; pend_we = 1'b0; m_rd_known = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clock); #1;
        n_checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_colour, drop, busy} !== {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, CLR})
            $display("FAIL reset_values got hs/vs/bl/col/drop/busy=%b required %b",
                     {vga_hs, vga_vs, vga_blank_n, vga_colour, drop, busy}, {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, CLR});
        else n_pass++;
        release_reset();
        $display("reset released");
    endtask

`ifdef CLEAR_ON_RESET_EN
    task automatic test_clear();
        int busy_cnt = 0;
        while (cyc < DEPTH + 4) begin
            if (busy === 1'b1) busy_cnt++;
            if (cyc % 997 == 5) tick(1'b1, $urandom_range(0, 159), $urandom_range(0, 119), RED);
            else tick(1'b0, 0, 0, 3'b000);
            n_checks++;
            if ({vga_hs, vga_vs, vga_blank_n, drop, busy} !== {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy})
                $display("FAIL clear_ctrl cyc=%0d got hs/vs/bl/drop/busy=%b required %b", cyc,
                         {vga_hs, vga_vs, vga_blank_n, drop, busy}, {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy});
            else n_pass++;
            if (exp_col_known) begin
                n_checks++;
                if (vga_colour !== exp_col) $display("FAIL clear_colour cyc=%0d got %b required %b", cyc, vga_colour, exp_col);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_cnt !== DEPTH) $display("FAIL busy_length got %0d required %0d", busy_cnt, DEPTH);
        else n_pass++;
        $display("clear sweep: busy for %0d cycles", busy_cnt);
    endtask
`endif

    task automatic test_fill();
        logic [2:0] col;
        for (int r = R0; r < R0 + 10; r++) begin
            for (int c = 0; c < 160; c++) begin
                col = 3'($urandom_range(0, 7));
                if (r == R0 + 5 && c == 10) col = RED;
                tick(1'b1, c, r, col);
                n_checks++;
                if ({vga_hs, vga_vs, vga_blank_n, drop, busy} !== {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy})
                    $display("FAIL fill_ctrl cyc=%0d got hs/vs/bl/drop/busy=%b required %b", cyc,
                             {vga_hs, vga_vs, vga_blank_n, drop, busy}, {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy});
                else n_pass++;
                if (exp_col_known) begin
                    n_checks++;
                    if (vga_colour !== exp_col) $display("FAIL fill_colour cyc=%0d got %b required %b", cyc, vga_colour, exp_col);
                    else n_pass++;
                end
            end
            $display("filled row %0d", r);
        end
    endtask

    task automatic test_drop();
        int xs [4];
        int ys [4];
        xs = '{160, 0, $urandom_range(161, 255), $urandom_range(0, 159)};
        ys = '{0, 120, $urandom_range(0, 127), $urandom_range(121, 127)};
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, xs[i], ys[i], RED);
            n_checks++;
            if (drop !== 1'b1) $display("FAIL drop_pulse x=%0d y=%0d got %b required 1", xs[i], ys[i], drop);
            else n_pass++;
            tick(1'b0, 0, 0, 3'b000);
            n_checks++;
            if (drop !== 1'b0) $display("FAIL drop_clear x=%0d y=%0d got %b required 0", xs[i], ys[i], drop);
            else n_pass++;
            $display("plot x=%0d y=%0d refused", xs[i], ys[i]);
        end
    endtask

    task automatic test_scan();
        rf_old = m_fb[(R0 + 7) * 160 + 20];
        rf_new = ~rf_old;
        while (cyc < SCAN_END) begin
            if (cyc == RF - 1) tick(1'b1, 20, R0 + 7, rf_new);
            else tick(1'b0, 0, 0, 3'b000);
            n_checks++;
            if ({vga_hs, vga_vs, vga_blank_n, drop, busy} !== {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy})
                $display("FAIL scan_ctrl cyc=%0d got hs/vs/bl/drop/busy=%b required %b", cyc,
                         {vga_hs, vga_vs, vga_blank_n, drop, busy}, {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy});
            else n_pass++;
            if (exp_col_known) begin
                n_checks++;
                if (vga_colour !== exp_col) $display("FAIL scan_colour cyc=%0d got %b required %b", cyc, vga_colour, exp_col);
                else n_pass++;
            end
            if (m_h(out_c) >= 40 && m_h(out_c) <= 43 && m_v(out_c) / 4 == R0 + 5) begin
                n_checks++;
                if (vga_colour !== RED) $display("FAIL red_pixel h=%0d v=%0d got %b required %b", m_h(out_c), m_v(out_c), vga_colour, RED);
                else n_pass++;
            end
            if (out_c == RF) begin
                n_checks++;
                if (vga_colour !== rf_old) $display("FAIL read_first_old got %b required %b", vga_colour, rf_old);
                else n_pass++;
            end
            if (out_c == RF + 1) begin
                n_checks++;
                if (vga_colour !== rf_new) $display("FAIL read_first_new got %b required %b", vga_colour, rf_new);
                else n_pass++;
            end
        end
        $display("scanned %0d lines", SCAN_END / H_TOT);
    endtask

    task automatic test_mid_frame_reset();
        while (m_h(cyc) != 300) tick(1'b0, 0, 0, 3'b000);
        tick(1'b1, 5, R0 + 1, RED);
        reset = 1'b1;
        #1;
        n_checks++;
        if ({vga_hs, vga_vs, vga_blank_n, vga_colour, drop, busy} !== {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, CLR})
            $display("FAIL midframe_reset got hs/vs/bl/col/drop/busy=%b required %b",
                     {vga_hs, vga_vs, vga_blank_n, vga_colour, drop, busy}, {1'b1, 1'b1, 1'b0, 3'b000, 1'b0, CLR});
        else n_pass++;
        repeat (2) @(posedge clock);
        #1;
        release_reset();
        $display("reset asserted mid-frame and released");
        for (int i = 0; i < 3 * H_TOT; i++) begin
            tick(1'b0, 0, 0, 3'b000);
            n_checks++;
            if ({vga_hs, vga_vs, vga_blank_n, drop, busy} !== {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy})
                $display("FAIL restart_ctrl cyc=%0d got hs/vs/bl/drop/busy=%b required %b", cyc,
                         {vga_hs, vga_vs, vga_blank_n, drop, busy}, {exp_hs, exp_vs, exp_blank, exp_drop, exp_busy});
            else n_pass++;
            if (exp_col_known) begin
                n_checks++;
                if (vga_colour !== exp_col) $display("FAIL restart_colour cyc=%0d got %b required %b", cyc, vga_colour, exp_col);
                else n_pass++;
            end
        end
        $display("restarted scan ran %0d lines", 3);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_fb[i] = 3'bxxx;
            m_known[i] = 1'b0;
        end
        cyc = 0; pend_we = 1'b0; m_rd = 3'b000; m_rd_known = 1'b0;
        test_reset();
`ifdef CLEAR_ON_RESET_EN
        test_clear();
`endif
        test_fill();
        test_drop();
        test_scan();
        test_mid_frame_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_pixel_sink.md
Name: vga_pixel_sink

Overview:
- Receiving end of the pixel-plot interface (plot/x/y/colour) driven by the keyboard GUI drawer.
- Stores each accepted pixel in a 160x120, 3-bit dual-port framebuffer.
- Continuously scans the framebuffer out as 640x480@60 VGA, replicating each stored pixel 4x horizontally and 4x vertically.
- Sits between the GUI drawing logic and the board VGA DAC pins; the clock is the 25 MHz pixel clock.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- H_VIS / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48, horizontal timing in clocks (total 800).
- V_VIS / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33, vertical timing in lines (total 525).
- BACKGROUND, 3'b111, colour written by the clear sweep (optional feature).

Ports:
- clock  in  1  pixel clock, 25 MHz.
- reset  in  1  asynchronous, active-high reset.
- plot  in  1  write strobe, one pixel per cycle it is high.
- x  in  8  pixel column.
- y  in  7  pixel row.
- colour  in  3  {R,G,B} pixel colour.
- busy  out  1  high while the framebuffer is being cleared; writes are refused.
- drop  out  1  one-cycle pulse when a plot is refused.
- vga_colour  out  3  {R,G,B} scan-out pixel, 0 during blanking.
- vga_hs  out  1  horizontal sync, active low.
- vga_vs  out  1  vertical sync, active low.
- vga_blank_n  out  1  high in the visible region.

Behaviour:
- Reset values (async, active-high):
  - vga_hs=1, vga_vs=1, vga_blank_n=0, vga_colour=0, drop=0.
  - h/v counters=0, write stage cleared.
  - busy=1 if CLEAR_ON_RESET_EN is defined, else 0.
  - Framebuffer contents are not reset.
- Write path:
  - plot is sampled at edge N.
  - Accepted when x<FB_W, y<FB_H and busy=0. {addr=y*160+x, colour} is registered and written to RAM at edge N+1.
  - addr is 15 bits, computed as (y<<7)+(y<<5)+x with no multiplier.
  - Refused if x>=160, y>=120 or busy=1: no RAM write, and drop=1 for the cycle after edge N.
  - Back-to-back plots are accepted every cycle; there is no backpressure beyond busy.
- Scan counters:
  - h counts 0..799 and wraps to 0; v increments when h wraps, counts 0..524 and wraps to 0.
  - Read address = v[8:2]*160 + h[9:2], used only when h<640 and v<480.
- Read path and alignment:
  - RAM read is synchronous (1 cycle), followed by an output register. Pixel latency is 2 clocks from the counter value.
  - hs, vs and blank_n are derived from the same counter value and delayed 2 stages so they align with vga_colour.
  - hs low for h in [656,751]; vs low for v in [490,491]; blank_n = (h<640 && v<480).
  - vga_colour is forced to 0 when the aligned blank_n is 0.
- Same-cycle read and write to the same address: the read returns old data (read-first). The new value is visible on the next read of that address.
- Reset mid-frame: counters restart at 0 and the scan restarts cleanly at frame top. Any in-flight write in the write stage is discarded.

Optional Feature:
- Macro: CLEAR_ON_RESET_EN.
- Defined:
  - After reset deasserts, a clear FSM runs IDLE->CLEAR->IDLE.
  - CLEAR writes BACKGROUND to addresses 0..19199, one per cycle, then busy drops.
  - busy is high for exactly 19200 cycles after the first edge following reset release.
  - Plots during busy are refused (drop pulses).
  - Reset during CLEAR restarts the sweep at address 0.
  - Scan-out keeps running during the clear.
- Undefined: no clear FSM; busy is tied 0; RAM powers up with undefined contents.

Decomposition:
- Shared package gui_pkg holds:
  - colour constants WHITE=3'b111, BLACK=3'b000, RED=3'b100;
  - FB_W, FB_H;
  - VGA timing constants.
- One sub-module, vga_timing_gen: h/v counters, hs/vs/blank generation and the 2-stage alignment delay.
- Framebuffer RAM is an inferred dual-port array inside vga_pixel_sink.

Test Plan:
- Reset release, then run 2 frames (2*800*525 clocks) -> hs pulse width 96 clocks every 800 clocks; vs low for 2 lines every 525 lines; blank_n high 640 clocks per visible line.
- plot=1, x=10, y=5, colour=RED, then scan the frame -> vga_colour=3'b100 exactly on h=40..43 and v=20..23; BLACK/other stored values elsewhere.
- plot with x=160,y=0, then x=0,y=120 -> drop pulses once each; addresses 0 and 19200-wrap remain unchanged.
- Write addr (0,0)=BLACK in the cycle its read address is presented -> old value shown that frame, BLACK the next frame.
- CLEAR_ON_RESET_EN: busy high exactly 19200 cycles; plot during busy -> drop; afterwards every visible pixel = BACKGROUND 3'b111.
- Assert reset mid-frame at h=300, v=200 -> outputs return to reset values immediately (async); after release, first vs pulse appears at v=490 of the new frame.
